// File: rtl/sb_tx_pkg.sv
// Shared types and constants for the sideband transmit scheduler.
// The scheduler multiplexes message sources onto the single sideband serializer.
package sb_tx_pkg;

    localparam int SB_WORD_W       = 64;
    localparam int SB_FRAME_CYCLES = 96;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_HDR  = 2'd1,
        SEND_DATA = 2'd2
    } sb_tx_state_e;

endpackage

// File: rtl/sb_rr_arbiter.sv
// Combinational round-robin pick: the first requesting index at or after ptr wins.
// Nothing is granted while en is low.
module sb_rr_arbiter #(
    parameter int  NUM_REQ = 3,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sb_tx_scheduler.sv
// Round-robin scheduler feeding the sideband serializer.
// Each 64-bit word is held for one full serializer frame.
module sb_tx_scheduler
    import sb_tx_pkg::*;
#(
    parameter int NUM_REQ      = 3,
    parameter int FRAME_CYCLES = SB_FRAME_CYCLES
) (
    input  logic                           pll_clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*SB_WORD_W-1:0]   req_hdr,
    input  logic [NUM_REQ-1:0]             req_has_data,
    input  logic [NUM_REQ*SB_WORD_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [SB_WORD_W-1:0]           sb_data,
    output logic                           sb_enable,
    output logic                           frame_start,
    output logic                           busy
);

    localparam int               IDX_W    = $clog2(NUM_REQ);
    localparam int               CNT_W    = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    sb_tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 has_data_q, has_data_d;
    logic [SB_WORD_W-1:0] hdr_q, hdr_d;
    logic [SB_WORD_W-1:0] data_q, data_d;
    logic [SB_WORD_W-1:0] sb_data_q, sb_data_d;
    logic                 sb_enable_q, sb_enable_d;
    logic                 frame_start_q, frame_start_d;

    logic                 frame_last;
    logic                 arb_en;
    logic [NUM_REQ-1:0]   gnt;
    logic [IDX_W-1:0]     gnt_idx;
    logic [SB_WORD_W-1:0] sel_hdr;
    logic [SB_WORD_W-1:0] sel_data;

    // Arbitrate only in IDLE or on the final cycle of a message, so a header
    // frame is always followed directly by its own data frame.
    assign frame_last = (cnt_q == CNT_LAST);
    assign arb_en     = (state_q == IDLE) ||
                        (frame_last && ((state_q == SEND_DATA) ||
                                        (state_q == SEND_HDR && !has_data_q)));

    sb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign sel_hdr  = req_hdr[int'(gnt_idx)*SB_WORD_W +: SB_WORD_W];
    assign sel_data = req_data[int'(gnt_idx)*SB_WORD_W +: SB_WORD_W];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rr_ptr_d      = rr_ptr_q;
        has_data_d    = has_data_q;
        hdr_d         = hdr_q;
        data_d        = data_q;
        sb_data_d     = sb_data_q;
        sb_enable_d   = sb_enable_q;
        frame_start_d = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (|gnt) begin
            state_d       = SEND_HDR;
            cnt_d         = '0;
            rr_ptr_d      = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
            has_data_d    = req_has_data[gnt_idx];
            hdr_d         = sel_hdr;
            data_d        = sel_data;
            sb_data_d     = sel_hdr;
            sb_enable_d   = 1'b1;
            frame_start_d = 1'b1;
        end else if (state_q == SEND_HDR && frame_last && has_data_q) begin
            state_d       = SEND_DATA;
            cnt_d         = '0;
            sb_data_d     = data_q;
            frame_start_d = 1'b1;
        end else if (state_q != IDLE && frame_last) begin
            state_d     = IDLE;
            cnt_d       = '0;
            sb_enable_d = 1'b0;
        end
    end

    always_ff @(posedge pll_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            rr_ptr_q      <= '0;
            has_data_q    <= 1'b0;
            sb_data_q     <= '0;
            sb_enable_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rr_ptr_q      <= rr_ptr_d;
            has_data_q    <= has_data_d;
            sb_data_q     <= sb_data_d;
            sb_enable_q   <= sb_enable_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Payload words are only ever read after a grant has loaded them.
    always_ff @(posedge pll_clk) begin
        hdr_q  <= hdr_d;
        data_q <= data_d;
    end

    assign req_ready   = gnt;
    assign sb_data     = sb_data_q;
    assign sb_enable   = sb_enable_q;
    assign busy        = sb_enable_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sb_tx_scheduler.sv
// Directed bench for sb_tx_scheduler: single, header+data, contention, fairness,
// no-preemption and mid-frame reset scenarios.
module tb_sb_tx_scheduler;

    localparam int NR = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*64-1:0] req_hdr = '0;
    logic [NR-1:0]    req_has_data = '0;
    logic [NR*64-1:0] req_data = '0;
    logic [NR-1:0]    req_ready;
    logic [63:0]      sb_data;
    logic             sb_enable;
    logic             frame_start;
    logic             busy;

    logic [NR-1:0]    sticky = '0;
    logic [NR-1:0]    set_mask = '0;
    logic [NR-1:0]    clr_mask = '0;

    int n_asserts = 0;
    int n_fail = 0;

    int          cyc, en_cycles, rises, glitch, onehot_err;
    logic        prev_en;
    logic [63:0] prev_data;
    int          gnt_log[$];
    int          gnt_time[$];
    logic [63:0] fs_words[$];
    int          fs_time[$];

    sb_tx_scheduler #(
        .NUM_REQ      (NR),
        .FRAME_CYCLES (96)
    ) dut (
        .pll_clk      (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_hdr      (req_hdr),
        .req_has_data (req_has_data),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .sb_data      (sb_data),
        .sb_enable    (sb_enable),
        .frame_start  (frame_start),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        cyc = 0; en_cycles = 0; rises = 0; glitch = 0; onehot_err = 0;
        prev_en = sb_enable; prev_data = sb_data;
        gnt_log.delete(); gnt_time.delete(); fs_words.delete(); fs_time.delete();
    endtask

    task automatic sample();
        int w;
        cyc++;
        if (req_ready != '0) begin
            if ($countones(req_ready) != 1) onehot_err++;
            w = 0;
            for (int i = NR - 1; i >= 0; i--) if (req_ready[i]) w = i;
            gnt_log.push_back(w);
            gnt_time.push_back(cyc);
        end
        if (frame_start) begin
            fs_words.push_back(sb_data);
            fs_time.push_back(cyc);
        end
        if (sb_enable) en_cycles++;
        if (sb_enable && !prev_en) rises++;
        if (sb_enable && prev_en && !frame_start && sb_data !== prev_data) glitch++;
        prev_en = sb_enable;
        prev_data = sb_data;
    endtask

    // One clock: requester inputs change 1 time unit after the rising edge,
    // outputs are sampled on the falling edge.
    task automatic cycle();
        logic [NR-1:0] acc;
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        req_valid = ((req_valid & ~(acc & ~sticky)) & ~clr_mask) | set_mask;
        set_mask = '0;
        clr_mask = '0;
        @(negedge clk);
        sample();
    endtask

    task automatic run_idle(input int maxc, input string tag);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while ((sb_enable || req_valid != '0) && n < maxc);
        chk({tag, " timeout"}, 64'(n < maxc), 64'd1);
    endtask

    task automatic set_req(input int i, input logic [63:0] h, input logic [63:0] d, input logic hd);
        req_hdr[64*i +: 64]  = h;
        req_data[64*i +: 64] = d;
        req_has_data[i]      = hd;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        req_valid = '0; sticky = '0; set_mask = '0; clr_mask = '0;
        repeat (2) cycle();
        chk("rst sb_data", sb_data, 64'd0);
        chk("rst sb_enable", 64'(sb_enable), 64'd0);
        chk("rst req_ready", 64'(req_ready), 64'd0);
        chk("rst frame_start", 64'(frame_start), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        clear_mon();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        reset_dut();

        // Single header-only message from requester 0.
        set_req(0, 64'hA5A5A5A5A5A5A5A5, 64'h1111111111111111, 1'b0);
        set_mask = 3'b001;
        cycle();
        chk("t1 ready grant", 64'(req_ready), 64'd1);
        chk("t1 busy at grant", 64'(busy), 64'd0);
        cycle();
        chk("t1 enable T+1", 64'(sb_enable), 64'd1);
        chk("t1 frame_start T+1", 64'(frame_start), 64'd1);
        chk("t1 sb_data T+1", sb_data, 64'hA5A5A5A5A5A5A5A5);
        chk("t1 ready drop", 64'(req_ready), 64'd0);
        run_idle(400, "t1");
        chk("t1 enable cycles", 64'(en_cycles), 64'd96);
        chk("t1 grant count", 64'(gnt_log.size()), 64'd1);
        chk("t1 frame count", 64'(fs_words.size()), 64'd1);
        chk("t1 fs latency", 64'(fs_time[0] - gnt_time[0]), 64'd1);
        chk("t1 glitch", 64'(glitch), 64'd0);
        chk("t1 data held idle", sb_data, 64'hA5A5A5A5A5A5A5A5);
        chk("t1 busy idle", 64'(busy), 64'd0);

        // Header plus data from requester 1.
        clear_mon();
        set_req(1, 64'hB4B4B4B4B4B4B4B4, 64'h0, 1'b1);
        set_mask = 3'b010;
        run_idle(600, "t2");
        chk("t2 enable cycles", 64'(en_cycles), 64'd192);
        chk("t2 enable rises", 64'(rises), 64'd1);
        chk("t2 grant idx", 64'(gnt_log[0]), 64'd1);
        chk("t2 frame count", 64'(fs_words.size()), 64'd2);
        chk("t2 hdr word", fs_words[0], 64'hB4B4B4B4B4B4B4B4);
        chk("t2 data word", fs_words[1], 64'h0);
        chk("t2 frame spacing", 64'(fs_time[1] - fs_time[0]), 64'd96);
        chk("t2 glitch", 64'(glitch), 64'd0);

        // Contention: all three valid right after reset.
        reset_dut();
        set_req(0, 64'hC0C0C0C0C0C0C0C0, 64'h0, 1'b0);
        set_req(1, 64'hC1C1C1C1C1C1C1C1, 64'h0, 1'b0);
        set_req(2, 64'hC2C2C2C2C2C2C2C2, 64'h0, 1'b0);
        set_mask = 3'b111;
        run_idle(1000, "t3");
        chk("t3 grant count", 64'(gnt_log.size()), 64'd3);
        chk("t3 grant 0", 64'(gnt_log[0]), 64'd0);
        chk("t3 grant 1", 64'(gnt_log[1]), 64'd1);
        chk("t3 grant 2", 64'(gnt_log[2]), 64'd2);
        chk("t3 word 1", fs_words[1], 64'hC1C1C1C1C1C1C1C1);
        chk("t3 enable cycles", 64'(en_cycles), 64'd288);
        chk("t3 enable rises", 64'(rises), 64'd1);
        chk("t3 onehot", 64'(onehot_err), 64'd0);
        chk("t3 data held idle", sb_data, 64'hC2C2C2C2C2C2C2C2);

        // Fairness: requesters 0 and 2 permanently valid.
        reset_dut();
        sticky = 3'b101;
        set_mask = 3'b101;
        begin
            int n;
            n = 0;
            do begin
                cycle();
                n++;
            end while (gnt_log.size() < 4 && n < 1000);
            chk("t4 grant wait timeout", 64'(n < 1000), 64'd1);
        end
        sticky = '0;
        clr_mask = 3'b101;
        run_idle(400, "t4");
        chk("t4 grant count", 64'(gnt_log.size()), 64'd4);
        chk("t4 grant 0", 64'(gnt_log[0]), 64'd0);
        chk("t4 grant 1", 64'(gnt_log[1]), 64'd2);
        chk("t4 grant 2", 64'(gnt_log[2]), 64'd0);
        chk("t4 grant 3", 64'(gnt_log[3]), 64'd2);
        chk("t4 enable rises", 64'(rises), 64'd1);

        // Data frame is not preempted by a request raised mid-header.
        reset_dut();
        set_req(0, 64'hE0E0E0E0E0E0E0E0, 64'hE1E1E1E1E1E1E1E1, 1'b1);
        set_req(1, 64'hF1F1F1F1F1F1F1F1, 64'h0, 1'b0);
        set_mask = 3'b001;
        repeat (10) cycle();
        set_mask = 3'b010;
        run_idle(1000, "t5");
        chk("t5 grant count", 64'(gnt_log.size()), 64'd2);
        chk("t5 grant order", 64'(gnt_log[1]), 64'd1);
        chk("t5 grant spacing", 64'(gnt_time[1] - gnt_time[0]), 64'd192);
        chk("t5 word data", fs_words[1], 64'hE1E1E1E1E1E1E1E1);
        chk("t5 word next hdr", fs_words[2], 64'hF1F1F1F1F1F1F1F1);
        chk("t5 enable cycles", 64'(en_cycles), 64'd288);
        chk("t5 enable rises", 64'(rises), 64'd1);
        chk("t5 glitch", 64'(glitch), 64'd0);

        // Reset asserted at cycle 40 of a header frame.
        clear_mon();
        set_req(0, 64'hD3D3D3D3D3D3D3D3, 64'h0, 1'b0);
        set_mask = 3'b001;
        cycle();
        repeat (40) cycle();
        chk("t6 enable before rst", 64'(sb_enable), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6 enable async", 64'(sb_enable), 64'd0);
        chk("t6 sb_data async", sb_data, 64'd0);
        chk("t6 busy async", 64'(busy), 64'd0);
        repeat (2) cycle();
        rst_n = 1'b1;
        clear_mon();
        repeat (150) cycle();
        chk("t6 enable after rst", 64'(en_cycles), 64'd0);
        chk("t6 no grant", 64'(gnt_log.size()), 64'd0);
        chk("t6 busy after rst", 64'(busy), 64'd0);
        chk("t6 sb_data after rst", sb_data, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
